// File: rtl/rx_frame_pkg.sv
// Package for the UART frame parser: SOF marker, parser state encoding and
// the clogb2 helper used to size the payload RAM byte address.
package rx_frame_pkg;

  localparam logic [7:0] SOF = 8'h7E;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_FLUSH,
    ST_CHK,
    ST_DONE
  } state_t;

  // Number of address bits needed to index 'value' locations.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = value - 1;
    while (v != 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer for the frame parser.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : restart the count (takes priority over en)
//   en           : count one cycle
//   expired      : high on the cycle the count reaches LIMIT
module rx_gap_timer
  import rx_frame_pkg::*;
#(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = clogb2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = en && !clr && (cnt == LAST);

endmodule

// File: rtl/rx_frame_parser.sv
// UART frame parser: SOF, CMD, LEN, payload[LEN] (+ CHK when CHECKSUM_EN is
// defined). Payload is packed little-endian into 32-bit words written to the
// payload RAM from byte address 0; start_rx then pulses with cmd_rx/len_rx.
//   clk, reset_n        : clock, asynchronous active-low reset
//   rx_valid, rx_byte   : received byte strobe and data
//   hold                : downstream busy, blocks acceptance of a new SOF
//   ram_we/addr/wdata   : word write port (addr is a word-aligned byte address)
//   start_rx            : frame complete pulse; cmd_rx/len_rx held until next frame
//   frame_err           : pulse on inter-byte timeout or checksum mismatch
// Configuration macro: CHECKSUM_EN (adds trailing XOR checksum byte).
module rx_frame_parser
  import rx_frame_pkg::*;
#(
  parameter int unsigned NUMBER         = 256,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  input  logic                       hold,
  output logic                       ram_we,
  output logic [clogb2(NUMBER)-1:0]  ram_addr,
  output logic [31:0]                ram_wdata,
  output logic                       start_rx,
  output logic [7:0]                 cmd_rx,
  output logic [7:0]                 len_rx,
  output logic                       frame_err
);

  localparam int unsigned AW = clogb2(NUMBER);

`ifdef CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CHK;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, len_q, byte_cnt;
  logic [31:0] word_buf;
  logic        expired, last_byte;
  logic [1:0]  lane;

  assign lane      = byte_cnt[1:0];
  assign last_byte = (byte_cnt == len_q - 8'd1);

  rx_gap_timer #(.LIMIT(TIMEOUT_CYCLES)) u_gap_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (rx_valid || (state_q == ST_HUNT)),
    .en      (state_q != ST_HUNT),
    .expired (expired)
  );

`ifdef CHECKSUM_EN
  logic [7:0] chk_acc;
  logic       chk_ok;
  assign chk_ok = (rx_byte == chk_acc);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_HUNT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT:    if (rx_valid && rx_byte == SOF && !hold) state_d = ST_CMD;
      ST_CMD:     if (rx_valid) state_d = ST_LEN;
      ST_LEN:     if (rx_valid) state_d = (rx_byte == 8'd0) ? ST_TAIL : ST_PAYLOAD;
      ST_PAYLOAD: if (rx_valid && last_byte) state_d = (lane == 2'd3) ? ST_TAIL : ST_FLUSH;
      ST_FLUSH:   state_d = ST_TAIL;
`ifdef CHECKSUM_EN
      ST_CHK:     if (rx_valid) state_d = chk_ok ? ST_DONE : ST_HUNT;
`endif
      ST_DONE:    state_d = ST_HUNT;
      default:    state_d = ST_HUNT;
    endcase
    if (expired) state_d = ST_HUNT;
  end

  // Datapath and registered outputs. Bytes arriving in FLUSH/DONE fall
  // through without effect. On timeout nothing else happens that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      start_rx  <= 1'b0;
      cmd_rx    <= '0;
      len_rx    <= '0;
      frame_err <= 1'b0;
      cmd_q     <= '0;
      len_q     <= '0;
      byte_cnt  <= '0;
      word_buf  <= '0;
`ifdef CHECKSUM_EN
      chk_acc   <= '0;
`endif
    end else begin
      ram_we    <= 1'b0;
      start_rx  <= 1'b0;
      frame_err <= 1'b0;
      if (expired) begin
        frame_err <= 1'b1;
      end else begin
        case (state_q)
          ST_HUNT: begin
            byte_cnt <= '0;
            word_buf <= '0;
          end
          ST_CMD: if (rx_valid) begin
            cmd_q <= rx_byte;
`ifdef CHECKSUM_EN
            chk_acc <= rx_byte;
`endif
          end
          ST_LEN: if (rx_valid) begin
            len_q <= rx_byte;
`ifdef CHECKSUM_EN
            chk_acc <= chk_acc ^ rx_byte;
`endif
          end
          ST_PAYLOAD: if (rx_valid) begin
`ifdef CHECKSUM_EN
            chk_acc <= chk_acc ^ rx_byte;
`endif
            if (lane == 2'd3) begin
              ram_we    <= 1'b1;
              ram_addr  <= AW'({byte_cnt[7:2], 2'b00});
              ram_wdata <= {rx_byte, word_buf[23:0]};
              word_buf  <= '0;
            end else begin
              word_buf[8*lane +: 8] <= rx_byte;
            end
            // byte_cnt stays on the last index so FLUSH can address it
            if (!last_byte) byte_cnt <= byte_cnt + 8'd1;
          end
          ST_FLUSH: begin
            ram_we    <= 1'b1;
            ram_addr  <= AW'({byte_cnt[7:2], 2'b00});
            ram_wdata <= word_buf;
            word_buf  <= '0;
          end
`ifdef CHECKSUM_EN
          ST_CHK: if (rx_valid && !chk_ok) frame_err <= 1'b1;
`endif
          ST_DONE: begin
            start_rx <= 1'b1;
            cmd_rx   <= cmd_q;
            len_rx   <= len_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
module tb_rx_frame_parser;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        reset_n, rx_valid, hold;
  logic [7:0]  rx_byte;
  logic        ram_we, start_rx, frame_err;
  logic [7:0]  ram_addr, cmd_rx, len_rx;
  logic [31:0] ram_wdata;

  always #5 clk = ~clk;

  rx_frame_parser #(.NUMBER(256), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .hold      (hold),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .start_rx  (start_rx),
    .cmd_rx    (cmd_rx),
    .len_rx    (len_rx),
    .frame_err (frame_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0] wq[$];
  int starts, errs, start_cyc, we_cyc, rxv_cyc;
  logic [7:0] s_cmd, s_len;
  logic [7:0] pl[256];

  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_we) begin
        wq.push_back({ram_addr, ram_wdata});
        we_cyc = cyc;
      end
      if (start_rx) begin
        starts++;
        start_cyc = cyc;
        s_cmd = cmd_rx;
        s_len = len_rx;
      end
      if (frame_err) errs++;
      if (rx_valid) rxv_cyc = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    starts = 0; errs = 0; start_cyc = -1; we_cyc = -1; rxv_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] l);
    logic [7:0] x;
    send_byte(8'h7E);
    send_byte(c);
    send_byte(l);
    x = c ^ l;
    for (int i = 0; i < int'(l); i++) begin
      send_byte(pl[i]);
      x = x ^ pl[i];
    end
`ifdef CHECKSUM_EN
    send_byte(x);
`endif
    repeat (6) @(posedge clk);
  endtask

  // expected start_rx cycle relative to the final write of a payload frame
  function automatic int exp_start();
`ifdef CHECKSUM_EN
    return rxv_cyc + 1;
`else
    return we_cyc + 1;
`endif
  endfunction

  initial begin
    logic ok;
    reset_n = 1'b0; rx_valid = 1'b0; hold = 1'b0; rx_byte = 8'h00;
    clear_mon();
    repeat (3) @(posedge clk); #2;
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_start_rx", 64'(start_rx), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_cmd_len", 64'({cmd_rx, len_rx, ram_addr}), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: LEN=0
    clear_mon();
    send_frame(8'h53, 8'h00);
    check("t1_writes", 64'(wq.size()), 64'd0);
    check("t1_starts", 64'(starts), 64'd1);
    check("t1_cmd", 64'(s_cmd), 64'h53);
    check("t1_len", 64'(s_len), 64'h00);
    check("t1_latency", 64'(start_cyc), 64'(rxv_cyc + 1));

    // 2: LEN=4, one full word
    clear_mon();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    send_frame(8'h41, 8'h04);
    check("t2_writes", 64'(wq.size()), 64'd1);
    if (wq.size() >= 1) check("t2_word0", 64'(wq[0]), 64'h00_44332211);
    check("t2_starts", 64'(starts), 64'd1);
    check("t2_cmd_len", 64'({s_cmd, s_len}), 64'h4104);
    check("t2_latency", 64'(start_cyc), 64'(exp_start()));

    // 3: LEN=6, full word plus flushed partial word
    clear_mon();
    for (int i = 0; i < 6; i++) pl[i] = 8'(i + 1);
    send_frame(8'h4B, 8'h06);
    check("t3_writes", 64'(wq.size()), 64'd2);
    if (wq.size() >= 2) begin
      check("t3_word0", 64'(wq[0]), 64'h00_04030201);
      check("t3_word1", 64'(wq[1]), 64'h04_00000605);
    end
    check("t3_starts", 64'(starts), 64'd1);
    check("t3_latency", 64'(start_cyc), 64'(exp_start()));

    // 4: timeout mid-frame, then a normal frame
    clear_mon();
    send_byte(8'h7E); send_byte(8'h56); send_byte(8'h08); send_byte(8'hAA);
    repeat (TO - 10) @(posedge clk);
    check("t4_no_early_err", 64'(errs), 64'd0);
    repeat (40) @(posedge clk);
    check("t4_err", 64'(errs), 64'd1);
    check("t4_no_start", 64'(starts), 64'd0);
    check("t4_no_write", 64'(wq.size()), 64'd0);
    clear_mon();
    pl[0] = 8'h99;
    send_frame(8'h61, 8'h01);
    check("t4_after_starts", 64'(starts), 64'd1);
    check("t4_after_cmd_len", 64'({s_cmd, s_len}), 64'h6101);
    if (wq.size() >= 1) check("t4_after_word", 64'(wq[0]), 64'h00_00000099);
    check("t4_after_writes", 64'(wq.size()), 64'd1);

    // 5: hold blocks SOF; hold mid-frame ignored; 7E as data
    clear_mon();
    hold = 1'b1;
    send_byte(8'h7E); send_byte(8'h53); send_byte(8'h00);
`ifdef CHECKSUM_EN
    send_byte(8'h53);
`endif
    repeat (6) @(posedge clk);
    check("t5_hold_no_start", 64'(starts), 64'd0);
    check("t5_hold_no_err", 64'(errs), 64'd0);
    hold = 1'b0;
    send_byte(8'h7E);
    hold = 1'b1;
    send_byte(8'h7E); send_byte(8'h02); send_byte(8'h7E); send_byte(8'h12);
`ifdef CHECKSUM_EN
    send_byte(8'h7E ^ 8'h02 ^ 8'h7E ^ 8'h12);
`endif
    repeat (6) @(posedge clk);
    hold = 1'b0;
    check("t5_starts", 64'(starts), 64'd1);
    check("t5_cmd_len", 64'({s_cmd, s_len}), 64'h7E02);
    check("t5_writes", 64'(wq.size()), 64'd1);
    if (wq.size() >= 1) check("t5_word", 64'(wq[0]), 64'h00_0000127E);

    // LEN=255 boundary: 64 words, last one partial at FC
    clear_mon();
    for (int i = 0; i < 256; i++) pl[i] = 8'(i);
    send_frame(8'h33, 8'hFF);
    check("tmax_writes", 64'(wq.size()), 64'd64);
    ok = (wq.size() == 64);
    for (int w = 0; w < 63 && ok; w++)
      if (wq[w] !== {8'(4 * w), 8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)}) ok = 1'b0;
    check("tmax_full_words", 64'(ok), 64'd1);
    if (wq.size() == 64) check("tmax_last_word", 64'(wq[63]), 64'hFC_00FEFDFC);
    check("tmax_len", 64'({s_cmd, s_len}), 64'h33FF);

`ifdef CHECKSUM_EN
    // 6: checksum good then bad
    clear_mon();
    send_byte(8'h7E); send_byte(8'h53); send_byte(8'h01); send_byte(8'h02); send_byte(8'h50);
    repeat (6) @(posedge clk);
    check("t6_good_start", 64'(starts), 64'd1);
    check("t6_good_err", 64'(errs), 64'd0);
    clear_mon();
    send_byte(8'h7E); send_byte(8'h53); send_byte(8'h01); send_byte(8'h02); send_byte(8'h51);
    repeat (6) @(posedge clk);
    check("t6_bad_start", 64'(starts), 64'd0);
    check("t6_bad_err", 64'(errs), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
